// File: rtl/bnn_pool_pkg.sv
// Shared types and helpers for the binary max-pool scheduler.
// Optional perf counter is enabled with MAXPOOL_SCHED_PERF_EN.
package bnn_pool_pkg;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        CAPTURE,
        WRITE,
        DONE
    } pool_state_e;

    function automatic int pool_out_size(int in);
        return in / 2;
    endfunction

    function automatic int ch_width(int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/maxpool_scheduler_if.sv
// Handshake and buffer bus between layer controller, feature buffers
// and the max-pool scheduler.
interface maxpool_scheduler_if
    import bnn_pool_pkg::*;
#(
    parameter int IMG_IN_SIZE = 28,
    parameter int IC          = 10
);
    localparam int OUT  = pool_out_size(IMG_IN_SIZE);
    localparam int CH_W = ch_width(IC);

    logic                               start;
    logic                               busy;
    logic                               done;
    logic                               rd_en;
    logic [CH_W-1:0]                    rd_addr;
    logic [IMG_IN_SIZE*IMG_IN_SIZE-1:0] rd_data;
    logic                               wr_en;
    logic [CH_W-1:0]                    wr_addr;
    logic [OUT*OUT-1:0]                 wr_data;
    logic                               wr_ready;

    modport master (
        output start, rd_data, wr_ready,
        input  busy, done, rd_en, rd_addr,
        input  wr_en, wr_addr, wr_data
    );

    modport slave (
        input  start, rd_data, wr_ready,
        output busy, done, rd_en, rd_addr,
        output wr_en, wr_addr, wr_data
    );

endinterface

// File: rtl/maxpool_window_or.sv
// Combinational 2x2 binary max (OR) over one square bitmap.
// Odd sizes drop the last row and column.
module maxpool_window_or
    import bnn_pool_pkg::*;
#(
    parameter int IMG_IN_SIZE = 28
) (
    input  logic [IMG_IN_SIZE*IMG_IN_SIZE-1:0] i_map,
    output logic [pool_out_size(IMG_IN_SIZE)**2-1:0] o_pool
);
    localparam int IN  = IMG_IN_SIZE;
    localparam int OUT = pool_out_size(IMG_IN_SIZE);

    for (genvar r = 0; r < OUT; r++) begin : g_row
        for (genvar c = 0; c < OUT; c++) begin : g_col
            assign o_pool[r*OUT+c] =
                i_map[(2*r)*IN + 2*c]
              | i_map[(2*r)*IN + 2*c + 1]
              | i_map[(2*r+1)*IN + 2*c]
              | i_map[(2*r+1)*IN + 2*c + 1];
        end
    end

endmodule

// File: rtl/maxpool_scheduler.sv
// Time-multiplexes one 2x2 OR-pool engine across IC channel bitmaps.
// MAXPOOL_SCHED_PERF_EN adds a saturating write-stall cycle counter.
module maxpool_scheduler
    import bnn_pool_pkg::*;
#(
    parameter int IMG_IN_SIZE = 28,
    parameter int IC          = 10
) (
    input  logic                clk,
    input  logic                rst,
    maxpool_scheduler_if.slave  bus
`ifdef MAXPOOL_SCHED_PERF_EN
    ,
    output logic [31:0]         stall_cycles
`endif
);
    localparam int OUT  = pool_out_size(IMG_IN_SIZE);
    localparam int CH_W = ch_width(IC);

    pool_state_e        r_state;
    pool_state_e        w_next;
    logic [CH_W-1:0]    r_ch;
    logic [OUT*OUT-1:0] r_result;
    logic [OUT*OUT-1:0] w_pool;
    logic               w_last;
    logic               w_accept_start;

    assign w_last         = (r_ch == CH_W'(IC - 1));
    assign w_accept_start = (r_state == IDLE) && bus.start;

    maxpool_window_or #(
        .IMG_IN_SIZE(IMG_IN_SIZE)
    ) u_window (
        .i_map  (bus.rd_data),
        .o_pool (w_pool)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (bus.start) w_next = READ;
            READ:    w_next = CAPTURE;
            CAPTURE: w_next = WRITE;
            WRITE: begin
                if (bus.wr_ready) begin
                    w_next = w_last ? DONE : READ;
                end
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Outputs depend on registered state only; rd_data/wr_ready never leak through.
    always_comb begin
        bus.busy    = (r_state != IDLE);
        bus.done    = (r_state == DONE);
        bus.rd_en   = (r_state == READ);
        bus.rd_addr = (r_state == READ) ? r_ch : '0;
        bus.wr_en   = (r_state == WRITE);
        bus.wr_addr = (r_state == WRITE) ? r_ch : '0;
        bus.wr_data = (r_state == WRITE) ? r_result : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ch <= '0;
        end else if (w_accept_start) begin
            r_ch <= '0;
        end else if (r_state == WRITE && bus.wr_ready && !w_last) begin
            r_ch <= r_ch + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_result <= '0;
        end else if (r_state == CAPTURE) begin
            r_result <= w_pool;
        end
    end

`ifdef MAXPOOL_SCHED_PERF_EN
    logic [31:0] r_stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall <= '0;
        end else if (w_accept_start) begin
            r_stall <= '0;
        end else if (r_state == WRITE && !bus.wr_ready && r_stall != '1) begin
            r_stall <= r_stall + 32'd1;
        end
    end

    assign stall_cycles = r_stall;
`endif

endmodule
